layer_4_maxpool_2x2: RTL and testbench
======================================

Name: layer_4_maxpool_2x2

Overview:
- Downstream consumer of one layer-4 feature-map stage.
- Takes the raster-order FP32 output stream of one feature map (IMG_SIZE x IMG_SIZE, one pixel per valid_in) and performs 2x2 max pooling with stride 2.
- Emits an (IMG_SIZE/2) x (IMG_SIZE/2) raster-order FP32 stream.
- One instance per feature map; feeds the next layer's input packing.

Parameters:
- DATA_WIDTH, 32, pixel width; IEEE-754 single precision.
- IMG_SIZE, 104, input width and height in pixels. Must be even and >= 2.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- data_in  input  DATA_WIDTH  input pixel, FP32.
- valid_in  input  1  data_in is valid this cycle; one pixel consumed per asserted cycle.
- data_out  output  DATA_WIDTH  pooled pixel, FP32.
- valid_out  output  1  data_out valid; single-cycle pulse per pooled pixel.
- frame_done  output  1  single-cycle pulse coincident with the last valid_out of a frame.

Behaviour:
- Reset: Rst low asynchronously clears col_cnt, row_cnt, pair_reg, data_out, valid_out and frame_done to 0. Row buffer contents are don't-care. Reset mid-frame abandons the frame; the next valid_in after release is pixel (0,0).
- Counters:
  - col_cnt counts 0..IMG_SIZE-1 and row_cnt counts 0..IMG_SIZE-1; both advance only on valid_in.
  - col_cnt wraps to 0 and increments row_cnt.
  - After pixel (IMG_SIZE-1, IMG_SIZE-1) both wrap to 0, so back-to-back frames need no gap.
- Gaps: valid_in may deassert for any number of cycles anywhere, including between frames. No state changes while valid_in is low.
- Compare function max(a,b):
  - key(x) = x ^ 32'h80000000 if x[31]=0, else ~x; compare keys unsigned.
  - The larger key wins; on equal keys, a wins.
  - Consequence: +0 beats -0. NaN gets no special handling and follows the key order.
- Even row (row_cnt[0]=0):
  - Even col: pair_reg <= data_in.
  - Odd col: rowbuf[col_cnt>>1] <= max(pair_reg, data_in).
  - No output.
- Odd row (row_cnt[0]=1):
  - Even col: pair_reg <= data_in.
  - Odd col: data_out <= max(rowbuf[col_cnt>>1], max(pair_reg, data_in)); valid_out <= 1.
- Row buffer: IMG_SIZE/2 entries x DATA_WIDTH; registers or inferred RAM with combinational or same-cycle read.
- Latency: valid_out rises exactly 1 cycle after the odd-row, odd-col input accepted.
- Output pulses: valid_out is low in every other cycle. data_out holds its last value when valid_out is low.
- frame_done = 1 in the same cycle as the valid_out produced by input pixel (IMG_SIZE-1, IMG_SIZE-1); 0 otherwise.
- Output count per frame: exactly (IMG_SIZE/2)^2 valid_out pulses, in raster order of the pooled grid.
- No backpressure: the consumer must accept every valid_out.

Test Plan:
- IMG_SIZE=4, continuous valid_in, pixels = FP32 of 1.0..16.0 raster -> outputs 6.0, 8.0, 14.0, 16.0 (32'h40c00000, 41000000, 41600000, 41800000); frame_done with the 4th output; each valid_out exactly 1 cycle after inputs 5, 7, 13, 15 (0-based).
- IMG_SIZE=4, all-negative frame -1.0..-16.0 -> outputs -1.0, -3.0, -9.0, -11.0 (32'hbf800000, c0400000, c1100000, c1300000).
- IMG_SIZE=4, window holding +0 (00000000), -0 (80000000), -1.0, -2.0 -> output 32'h00000000. Window holding 5.0, -7.0, -0, 0.5 -> 32'h40a00000.
- IMG_SIZE=4, valid_in toggled with random 0-3 idle cycles between pixels, data as scenario 1 -> identical output values and order; each valid_out 1 cycle after its triggering input.
- Rst pulsed low after 6 pixels of a frame, then a full fresh frame as scenario 1 -> no outputs from the aborted frame; exactly the 4 scenario-1 outputs follow.
- IMG_SIZE=104, two back-to-back frames of random finite FP32 values with no gap -> 2704 outputs per frame matching the reference model; frame_done asserted exactly twice.

Source files
------------

// File: rtl/layer_4_maxpool_2x2_if.sv
// rtl/layer_4_maxpool_2x2_if.sv - pixel stream in / pooled stream out bundle for the 2x2 max pool
interface layer_4_maxpool_2x2_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  frame_done;

  modport master (
    output data_in, valid_in,
    input  data_out, valid_out, frame_done
  );

  modport slave (
    input  data_in, valid_in,
    output data_out, valid_out, frame_done
  );
endinterface

// File: rtl/layer_4_maxpool_2x2.sv
// rtl/layer_4_maxpool_2x2.sv - 2x2 stride-2 FP32 max pooling over a raster-order feature map
module layer_4_maxpool_2x2 #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_SIZE   = 104
) (
  input  logic                  Clk,
  input  logic                  Rst,
  layer_4_maxpool_2x2_if.slave  px
);
  localparam int HALF = IMG_SIZE / 2;
  localparam int CW   = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam int BW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_SIZE - 1);

  // Mapping FP32 to a monotone unsigned key lets one integer compare order
  // all values, with -0 < +0 and NaNs placed by their bit pattern.
  function automatic logic [DATA_WIDTH-1:0] fp_max(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] ka;
    logic [DATA_WIDTH-1:0] kb;
    ka = a[DATA_WIDTH-1] ? ~a : (a ^ {1'b1, {(DATA_WIDTH-1){1'b0}}});
    kb = b[DATA_WIDTH-1] ? ~b : (b ^ {1'b1, {(DATA_WIDTH-1){1'b0}}});
    return (kb > ka) ? b : a;
  endfunction

  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         row_q, row_d;
  logic [DATA_WIDTH-1:0] pair_q, pair_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  frame_done_q, frame_done_d;

  logic [DATA_WIDTH-1:0] rowbuf_q [HALF];
  logic [BW-1:0]         buf_idx;
  logic                  buf_we;
  logic [DATA_WIDTH-1:0] pair_max;

  assign buf_idx  = BW'(col_q >> 1);
  assign pair_max = fp_max(pair_q, px.data_in);

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    pair_d       = pair_q;
    data_out_d   = data_out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    buf_we       = 1'b0;

    if (px.valid_in) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (!col_q[0]) begin
        pair_d = px.data_in;
      end else if (!row_q[0]) begin
        buf_we = 1'b1;
      end else begin
        // Bottom pair completes the window; top pair max was parked in rowbuf.
        data_out_d   = fp_max(rowbuf_q[buf_idx], pair_max);
        valid_out_d  = 1'b1;
        frame_done_d = (row_q == LAST) && (col_q == LAST);
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      data_out_q   <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pair_q       <= pair_d;
      data_out_q   <= data_out_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Row buffer contents are don't-care after reset, so it carries no reset.
  always_ff @(posedge Clk) begin
    if (buf_we) begin
      rowbuf_q[buf_idx] <= pair_max;
    end
  end

  assign px.data_out   = data_out_q;
  assign px.valid_out  = valid_out_q;
  assign px.frame_done = frame_done_q;
endmodule

// File: tb/tb_layer_4_maxpool_2x2.sv
// tb/tb_layer_4_maxpool_2x2.sv - scoreboard bench for the 2x2 max pool at IMG_SIZE 4 and 104
module tb_layer_4_maxpool_2x2;
  localparam int S4   = 4;
  localparam int S104 = 104;
  localparam int N104 = S104 * S104;

  typedef struct {
    logic [31:0] d;
    logic        fd;
    longint      due;
  } exp_t;

  logic   clk = 1'b0;
  logic   rst4_n;
  logic   rst104_n;
  longint cyc = 0;
  int     total = 0;
  int     bad = 0;
  int     fd104 = 0;
  logic [31:0] last4 = '0;
  logic [31:0] last104 = '0;

  exp_t        q4[$];
  exp_t        q104[$];
  logic [31:0] frame4 [S4*S4];
  logic [31:0] frame104 [2*N104];

  layer_4_maxpool_2x2_if #(.DATA_WIDTH(32)) if4 ();
  layer_4_maxpool_2x2_if #(.DATA_WIDTH(32)) if104 ();

  layer_4_maxpool_2x2 #(.DATA_WIDTH(32), .IMG_SIZE(S4)) dut4 (
    .Clk(clk), .Rst(rst4_n), .px(if4.slave)
  );
  layer_4_maxpool_2x2 #(.DATA_WIDTH(32), .IMG_SIZE(S104)) dut104 (
    .Clk(clk), .Rst(rst104_n), .px(if104.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Ordering of FP32 values: positive beats negative, +0 beats -0,
  // larger magnitude wins among positives, smaller among negatives.
  function automatic bit fp_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return b[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic logic [31:0] max4(input logic [31:0] a, input logic [31:0] b,
                                       input logic [31:0] c, input logic [31:0] d);
    logic [31:0] m;
    m = a;
    if (fp_gt(b, m)) m = b;
    if (fp_gt(c, m)) m = c;
    if (fp_gt(d, m)) m = d;
    return m;
  endfunction

  function automatic logic [31:0] f32(input real r);
    logic [63:0] b;
    b = $realtobits(r);
    if (r == 0.0) return {b[63], 31'b0};
    return {b[63], 8'(b[62:52] - 11'd896), b[51:29]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    return {1'($urandom), 8'($urandom_range(0, 254)), 23'($urandom)};
  endfunction

  function automatic logic [31:0] pool4(input int pr, input int pc);
    int b;
    b = 2 * pr * S4 + 2 * pc;
    return max4(frame4[b], frame4[b+1], frame4[b+S4], frame4[b+S4+1]);
  endfunction

  function automatic logic [31:0] pool104(input int f, input int pr, input int pc);
    int b;
    b = f * N104 + 2 * pr * S104 + 2 * pc;
    return max4(frame104[b], frame104[b+1], frame104[b+S104], frame104[b+S104+1]);
  endfunction

  task automatic drive4(input int max_gap, input int npix, input bit push);
    for (int i = 0; i < npix; i++) begin
      int r, c;
      r = i / S4;
      c = i % S4;
      repeat ($urandom_range(0, max_gap)) begin
        @(negedge clk);
        if4.valid_in = 1'b0;
      end
      @(negedge clk);
      if4.valid_in = 1'b1;
      if4.data_in  = frame4[i];
      if (push && r[0] && c[0])
        q4.push_back('{pool4(r / 2, c / 2), (i == S4 * S4 - 1), cyc + 1});
    end
  endtask

  task automatic end4();
    @(negedge clk);
    if4.valid_in = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst4_n) last4 = '0;
    if (if4.valid_out) begin
      if (q4.size() == 0) chk("dut4 spurious valid_out", 1, 0);
      else begin
        e = q4.pop_front();
        chk("dut4 data_out", if4.data_out, e.d);
        chk("dut4 frame_done", if4.frame_done, e.fd);
        chk("dut4 latency", cyc, e.due);
      end
      last4 = if4.data_out;
    end else begin
      chk("dut4 data_out hold", if4.data_out, last4);
      if (if4.frame_done) chk("dut4 frame_done without valid_out", 1, 0);
    end
    while (q4.size() > 0 && q4[0].due < cyc) begin
      chk("dut4 missing output", 0, 1);
      void'(q4.pop_front());
    end

    if (!rst104_n) last104 = '0;
    if (if104.frame_done) fd104++;
    if (if104.valid_out) begin
      if (q104.size() == 0) chk("dut104 spurious valid_out", 1, 0);
      else begin
        e = q104.pop_front();
        chk("dut104 data_out", if104.data_out, e.d);
        chk("dut104 frame_done", if104.frame_done, e.fd);
        chk("dut104 latency", cyc, e.due);
      end
      last104 = if104.data_out;
    end else begin
      chk("dut104 data_out hold", if104.data_out, last104);
      if (if104.frame_done) chk("dut104 frame_done without valid_out", 1, 0);
    end
    while (q104.size() > 0 && q104[0].due < cyc) begin
      chk("dut104 missing output", 0, 1);
      void'(q104.pop_front());
    end
  end

  initial begin
    rst4_n = 1'b0;
    rst104_n = 1'b0;
    if4.valid_in = 1'b0;
    if4.data_in = '0;
    if104.valid_in = 1'b0;
    if104.data_in = '0;
    repeat (3) @(negedge clk);
    chk("reset dut4 data_out", if4.data_out, 0);
    chk("reset dut4 valid_out", if4.valid_out, 0);
    chk("reset dut4 frame_done", if4.frame_done, 0);
    chk("reset dut104 data_out", if104.data_out, 0);
    chk("reset dut104 valid_out", if104.valid_out, 0);
    chk("reset dut104 frame_done", if104.frame_done, 0);
    rst4_n = 1'b1;
    rst104_n = 1'b1;

    for (int i = 0; i < S4 * S4; i++) frame4[i] = f32(real'(i + 1));
    drive4(0, S4 * S4, 1'b1);
    end4();

    for (int i = 0; i < S4 * S4; i++) frame4[i] = f32(-real'(i + 1));
    drive4(0, S4 * S4, 1'b1);
    end4();

    for (int i = 0; i < S4 * S4; i++) frame4[i] = rnd_fp();
    frame4[0] = 32'h00000000;
    frame4[1] = 32'h80000000;
    frame4[4] = f32(-1.0);
    frame4[5] = f32(-2.0);
    frame4[2] = f32(5.0);
    frame4[3] = f32(-7.0);
    frame4[6] = 32'h80000000;
    frame4[7] = f32(0.5);
    drive4(0, S4 * S4, 1'b1);
    end4();

    for (int i = 0; i < S4 * S4; i++) frame4[i] = f32(real'(i + 1));
    drive4(3, S4 * S4, 1'b1);
    end4();

    // Abort after 6 pixels; reset lands before the pixel-5 pulse can be observed.
    for (int i = 0; i < S4 * S4; i++) frame4[i] = f32(real'(100 + i));
    drive4(0, 6, 1'b0);
    @(posedge clk);
    #1;
    rst4_n = 1'b0;
    if4.valid_in = 1'b0;
    @(negedge clk);
    chk("abort reset data_out", if4.data_out, 0);
    chk("abort reset valid_out", if4.valid_out, 0);
    @(negedge clk);
    rst4_n = 1'b1;
    for (int i = 0; i < S4 * S4; i++) frame4[i] = f32(real'(i + 1));
    drive4(1, S4 * S4, 1'b1);
    end4();

    for (int i = 0; i < 2 * N104; i++) frame104[i] = rnd_fp();
    for (int i = 0; i < 2 * N104; i++) begin
      int f, p, r, c;
      f = i / N104;
      p = i % N104;
      r = p / S104;
      c = p % S104;
      @(negedge clk);
      if104.valid_in = 1'b1;
      if104.data_in  = frame104[i];
      if (r[0] && c[0])
        q104.push_back('{pool104(f, r / 2, c / 2), (p == N104 - 1), cyc + 1});
    end
    @(negedge clk);
    if104.valid_in = 1'b0;

    repeat (5) @(negedge clk);
    chk("dut4 scoreboard drained", q4.size(), 0);
    chk("dut104 scoreboard drained", q104.size(), 0);
    chk("dut104 frame_done count", fd104, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
